skullfet_selftest: RTL



---
 rtl/skullfet_selftest_pkg.sv | 30 +++
 rtl/skullfet_sync2.sv | 23 ++
 rtl/skullfet_selftest.sv | 100 ++++++++++
 3 files changed

// File: rtl/skullfet_selftest_pkg.sv
// Shared types and the stimulus/response table for the SkullFET cell self-test.
// Bit order: stim = {a, b, set, reset}, expected = {inv, nand, q, q_bar}.
package skullfet_selftest_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int NUM_VECTORS = 6;

   typedef struct packed {
      logic [3:0] stim;
      logic [3:0] expected;
   } vector_t;

   // Vectors 1, 3 and 5 leave set=reset=0 to prove the SR cell holds its state.
   localparam vector_t VECTORS [NUM_VECTORS] = '{
      '{4'b0010, 4'b1110},
      '{4'b0100, 4'b1110},
      '{4'b1001, 4'b0101},
      '{4'b1100, 4'b0001},
      '{4'b1110, 4'b0010},
      '{4'b0000, 4'b1110}
   };

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchronizer for asynchronous cell outputs; synchronous active-high reset.
module skullfet_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/skullfet_selftest.sv
// Sequenced stimulus/response checker for the SkullFET inverter, NAND and SR flip-flop.
// Each vector takes APPLY (1) + SETTLE (SETTLE_CYCLES) + CHECK (1) cycles.
module skullfet_selftest
   import skullfet_selftest_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_set,
   output logic       dut_reset,
   input  logic       inv_y,
   input  logic       nand_y,
   input  logic       ff_q,
   input  logic       ff_q_bar,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] fail_mask,
   output logic [2:0] vec_idx
);

   // start is a one-cycle request, accepted only in IDLE or DONE; while busy it is ignored.
   state_t     state;
   logic [3:0] settle_cnt;
   logic [3:0] resp_sync;
   vector_t    cur_vec;
   logic       mismatch;
   logic [5:0] mask_next;

   skullfet_sync2 #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({inv_y, nand_y, ff_q, ff_q_bar}),
      .q   (resp_sync)
   );

   assign cur_vec  = VECTORS[vec_idx];
   assign mismatch = (resp_sync != cur_vec.expected);

   always_comb begin
      mask_next = fail_mask;
      if (mismatch) mask_next[vec_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
         dut_set    <= 1'b0;
         dut_reset  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_mask  <= '0;
         vec_idx    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= APPLY;
                  vec_idx   <= '0;
                  fail_mask <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
               end
            end
            APPLY: begin
               {dut_a, dut_b, dut_set, dut_reset} <= cur_vec.stim;
               settle_cnt <= 4'(SETTLE_CYCLES - 1);
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == 4'd0) state <= CHECK;
               else settle_cnt <= settle_cnt - 4'd1;
            end
            CHECK: begin
               fail_mask <= mask_next;
               if (vec_idx == 3'(NUM_VECTORS - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (mask_next == 6'd0);
               end else begin
                  vec_idx <= vec_idx + 3'd1;
                  state   <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
